// File: rtl/fir_coef_sequencer.sv
// Coefficient-set store and load sequencer for the configurable FIR: holds several tap sets,
// drains/restarts the FIR on a set change, streams the chosen set, then bridges the sample path.
module fir_coef_sequencer #(
  parameter int G_NUM_SETS_LOG2 = 2,
  parameter int G_NUM_TAPS_LOG2 = 4,
  parameter int G_TAP_WIDTH     = 16,
  parameter int G_DATA_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [G_NUM_SETS_LOG2-1:0] coef_wr_set,
  input  logic [G_NUM_TAPS_LOG2-1:0] coef_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]     coef_wr_data,
  input  logic                       coef_wr_valid,
  output logic                       coef_wr_ready,
  input  logic [G_NUM_SETS_LOG2-1:0] sel_set,
  input  logic                       sel_valid,
  output logic                       sel_ready,
  output logic [G_NUM_SETS_LOG2-1:0] active_set,
  output logic                       loaded,
  output logic                       busy,
  output logic                       fir_enable,
  output logic [G_TAP_WIDTH-1:0]     fir_tap_din,
  output logic                       fir_tap_din_valid,
  input  logic                       fir_tap_din_ready,
  input  logic [G_DATA_WIDTH-1:0]    s_din,
  input  logic                       s_din_valid,
  output logic                       s_din_ready,
  output logic [G_DATA_WIDTH-1:0]    fir_din,
  output logic                       fir_din_valid,
  input  logic                       fir_din_ready,
  input  logic [G_DATA_WIDTH-1:0]    fir_dout,
  input  logic                       fir_dout_valid,
  output logic                       fir_dout_ready,
  output logic [G_DATA_WIDTH-1:0]    m_dout,
  output logic                       m_dout_valid,
  input  logic                       m_dout_ready
);

  localparam int T  = 2**G_NUM_TAPS_LOG2;
  localparam int NW = 2**(G_NUM_SETS_LOG2 + G_NUM_TAPS_LOG2);
  localparam logic [G_NUM_TAPS_LOG2-1:0] IDX_ONE  = G_NUM_TAPS_LOG2'(1);
  localparam logic [G_NUM_TAPS_LOG2-1:0] IDX_LAST = G_NUM_TAPS_LOG2'(T-1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DRAIN   = 3'd1;
  localparam logic [2:0] RESTART = 3'd2;
  localparam logic [2:0] LOAD    = 3'd3;
  localparam logic [2:0] RUN     = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [G_NUM_SETS_LOG2-1:0] sel_q, sel_d;
  logic [G_NUM_SETS_LOG2-1:0] active_q, active_d;
  logic                       loaded_q, loaded_d;
  logic                       outst_q, outst_d;
  logic                       rcnt_q, rcnt_d;
  logic                       tap_vld_q, tap_vld_d;
  logic [G_NUM_TAPS_LOG2-1:0] idx_q, idx_d;
  logic [G_NUM_TAPS_LOG2-1:0] rd_idx;
  logic                       rd_en;
  logic [G_TAP_WIDTH-1:0]     mem [NW];
  logic [G_TAP_WIDTH-1:0]     rd_q;

  logic run, sel_hs, tap_hs, din_hs, dout_hs, wr_hs;

  assign run            = (state_q == RUN);
  assign sel_ready      = (state_q == IDLE) || run;
  assign sel_hs         = sel_valid && sel_ready;
  assign tap_hs         = tap_vld_q && fir_tap_din_ready;
  assign coef_wr_ready  = !((state_q == LOAD) && (coef_wr_set == sel_q));
  assign wr_hs          = coef_wr_valid && coef_wr_ready;

  assign fir_din        = run ? s_din : '0;
  assign fir_din_valid  = run && s_din_valid;
  assign s_din_ready    = run && fir_din_ready;
  assign din_hs         = fir_din_valid && fir_din_ready;

  assign m_dout         = fir_dout;
  assign m_dout_valid   = fir_dout_valid;
  assign fir_dout_ready = m_dout_ready;
  assign dout_hs        = fir_dout_valid && fir_dout_ready;

  assign busy              = (state_q == DRAIN) || (state_q == RESTART) || (state_q == LOAD);
  assign fir_enable        = (state_q == DRAIN) || (state_q == LOAD) || run;
  assign fir_tap_din_valid = tap_vld_q;
  assign fir_tap_din       = tap_vld_q ? rd_q : '0;
  assign active_set        = active_q;
  assign loaded            = loaded_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    active_d  = active_q;
    loaded_d  = loaded_q;
    tap_vld_d = tap_vld_q;
    idx_d     = idx_q;
    rd_en     = 1'b0;
    rd_idx    = idx_q;
    rcnt_d    = (state_q == RESTART) ? ~rcnt_q : 1'b0;
    // A new sample wins over a simultaneous result so the flag never drops early
    outst_d   = din_hs ? 1'b1 : (dout_hs ? 1'b0 : outst_q);
    case (state_q)
      IDLE: if (sel_hs) begin
        sel_d   = sel_set;
        state_d = RESTART;
      end
      RUN: if (sel_hs) begin
        sel_d   = sel_set;
        state_d = DRAIN;
      end
      DRAIN: if (!outst_q) state_d = RESTART;
      RESTART: begin
        idx_d     = '0;
        tap_vld_d = 1'b0;
        if (rcnt_q) state_d = LOAD;
      end
      LOAD: begin
        if (!tap_vld_q) begin
          rd_en     = 1'b1;
          tap_vld_d = 1'b1;
        end else if (tap_hs) begin
          if (idx_q == IDX_LAST) begin
            tap_vld_d = 1'b0;
            active_d  = sel_q;
            loaded_d  = 1'b1;
            state_d   = RUN;
          end else begin
            idx_d  = idx_q + IDX_ONE;
            rd_idx = idx_q + IDX_ONE;
            rd_en  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      active_q  <= '0;
      loaded_q  <= 1'b0;
      outst_q   <= 1'b0;
      rcnt_q    <= 1'b0;
      tap_vld_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      active_q  <= active_d;
      loaded_q  <= loaded_d;
      outst_q   <= outst_d;
      rcnt_q    <= rcnt_d;
      tap_vld_q <= tap_vld_d;
      idx_q     <= idx_d;
    end
  end

  // Coefficient RAM: host write port, registered read held until the next issued read
  always_ff @(posedge clk) begin
    if (wr_hs) mem[{coef_wr_set, coef_wr_addr}] <= coef_wr_data;
    if (rd_en) rd_q <= mem[{sel_q, rd_idx}];
  end

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// Directed bench for fir_coef_sequencer: load timing, tap backpressure, drain, write blocking, reset.
module tb_fir_coef_sequencer;

  logic        clk;
  logic        reset;
  logic [1:0]  coef_wr_set;
  logic [3:0]  coef_wr_addr;
  logic [15:0] coef_wr_data;
  logic        coef_wr_valid;
  logic        coef_wr_ready;
  logic [1:0]  sel_set;
  logic        sel_valid;
  logic        sel_ready;
  logic [1:0]  active_set;
  logic        loaded;
  logic        busy;
  logic        fir_enable;
  logic [15:0] fir_tap_din;
  logic        fir_tap_din_valid;
  logic        fir_tap_din_ready;
  logic [15:0] s_din;
  logic        s_din_valid;
  logic        s_din_ready;
  logic [15:0] fir_din;
  logic        fir_din_valid;
  logic        fir_din_ready;
  logic [15:0] fir_dout;
  logic        fir_dout_valid;
  logic        fir_dout_ready;
  logic [15:0] m_dout;
  logic        m_dout_valid;
  logic        m_dout_ready;

  int n_chk;
  int n_fail;
  logic [15:0] model [4][16];

  fir_coef_sequencer dut (
    .clk(clk), .reset(reset),
    .coef_wr_set(coef_wr_set), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .coef_wr_valid(coef_wr_valid), .coef_wr_ready(coef_wr_ready),
    .sel_set(sel_set), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .active_set(active_set), .loaded(loaded), .busy(busy), .fir_enable(fir_enable),
    .fir_tap_din(fir_tap_din), .fir_tap_din_valid(fir_tap_din_valid),
    .fir_tap_din_ready(fir_tap_din_ready),
    .s_din(s_din), .s_din_valid(s_din_valid), .s_din_ready(s_din_ready),
    .fir_din(fir_din), .fir_din_valid(fir_din_valid), .fir_din_ready(fir_din_ready),
    .fir_dout(fir_dout), .fir_dout_valid(fir_dout_valid), .fir_dout_ready(fir_dout_ready),
    .m_dout(m_dout), .m_dout_valid(m_dout_valid), .m_dout_ready(m_dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input int set, input int addr, input logic [15:0] data);
    coef_wr_set   = 2'(set);
    coef_wr_addr  = 4'(addr);
    coef_wr_data  = data;
    coef_wr_valid = 1'b1;
    @(negedge clk);
    coef_wr_valid = 1'b0;
    model[set][addr] = data;
  endtask

  task automatic check_run(input int set);
    check("run_busy", 32'(busy), 0);
    check("run_en", 32'(fir_enable), 1);
    check("run_tap_vld", 32'(fir_tap_din_valid), 0);
    check("run_active", 32'(active_set), 32'(set));
    check("run_loaded", 32'(loaded), 1);
    check("run_sel_rdy", 32'(sel_ready), 1);
  endtask

  // Entered at the negedge of the first RESTART cycle.
  task automatic load_check(input int set, input bit toggle, input bit extra);
    int n;
    int cyc;
    bit stalled;
    logic [15:0] prev;
    n = 0; cyc = 0; stalled = 1'b0; prev = '0;
    #1;
    check("restart_en0", 32'(fir_enable), 0);
    check("restart_busy", 32'(busy), 1);
    @(negedge clk); #1;
    check("restart_en1", 32'(fir_enable), 0);
    @(negedge clk); #1;
    check("load_en", 32'(fir_enable), 1);
    check("load_first_vld", 32'(fir_tap_din_valid), 0);
    while (n < 16 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      fir_tap_din_ready = toggle ? cyc[0] : 1'b1;
      coef_wr_valid = 1'b0;
      if (extra && cyc == 1) begin
        coef_wr_set = 2'd2; coef_wr_addr = 4'd0; coef_wr_data = 16'hDEAD; coef_wr_valid = 1'b1;
      end
      if (extra && cyc == 2) begin
        coef_wr_set = 2'd3; coef_wr_addr = 4'd5; coef_wr_data = 16'h03AA; coef_wr_valid = 1'b1;
      end
      if (extra && cyc == 3) begin
        sel_set = 2'd3; sel_valid = 1'b1;
      end
      #1;
      if (extra && cyc == 1) check("wr_loading_set", 32'(coef_wr_ready), 0);
      if (extra && cyc == 2) begin
        check("wr_other_set", 32'(coef_wr_ready), 1);
        model[3][5] = 16'h03AA;
      end
      if (extra && cyc == 3) check("sel_while_busy", 32'(sel_ready), 0);
      check("tap_vld", 32'(fir_tap_din_valid), 1);
      if (stalled) check("tap_hold", 32'(fir_tap_din), 32'(prev));
      if (fir_tap_din_ready) begin
        check("tap_data", 32'(fir_tap_din), 32'(model[set][n]));
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev = fir_tap_din;
      end
    end
    if (n < 16) check("tap_timeout", 32'(n), 16);
    @(negedge clk);
    coef_wr_valid = 1'b0;
    fir_tap_din_ready = 1'b0;
    #1;
    check_run(set);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    coef_wr_set = '0; coef_wr_addr = '0; coef_wr_data = '0; coef_wr_valid = 1'b0;
    sel_set = '0; sel_valid = 1'b0; fir_tap_din_ready = 1'b0;
    s_din = '0; s_din_valid = 1'b0; fir_din_ready = 1'b0;
    fir_dout = '0; fir_dout_valid = 1'b0; m_dout_ready = 1'b0;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 16; a++) model[s][a] = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_wr_rdy", 32'(coef_wr_ready), 1);
    check("rst_sel_rdy", 32'(sel_ready), 1);
    check("rst_active", 32'(active_set), 0);
    check("rst_loaded", 32'(loaded), 0);
    check("rst_en", 32'(fir_enable), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tap_vld", 32'(fir_tap_din_valid), 0);
    check("rst_s_rdy", 32'(s_din_ready), 0);
    reset = 1'b0;

    for (int s = 1; s < 4; s++)
      for (int a = 0; a < 16; a++) host_write(s, a, 16'((s << 8) + a));

    // Select set 1 from IDLE, tap ready held high
    sel_set = 2'd1; sel_valid = 1'b1; #1;
    check("idle_sel_rdy", 32'(sel_ready), 1);
    @(negedge clk); sel_valid = 1'b0;
    load_check(1, 1'b0, 1'b0);

    // Reload set 1 from RUN with nothing outstanding, tap ready toggling
    sel_set = 2'd1; sel_valid = 1'b1; #1;
    check("run_sel_rdy1", 32'(sel_ready), 1);
    @(negedge clk); sel_valid = 1'b0; #1;
    check("drain1_busy", 32'(busy), 1);
    check("drain1_en", 32'(fir_enable), 1);
    @(negedge clk);
    load_check(1, 1'b1, 1'b0);

    // One sample in flight, result withheld, then switch to set 2
    s_din = 16'h1234; s_din_valid = 1'b1; fir_din_ready = 1'b1; #1;
    check("smp_vld", 32'(fir_din_valid), 1);
    check("smp_rdy", 32'(s_din_ready), 1);
    check("smp_data", 32'(fir_din), 32'h1234);
    @(negedge clk);
    fir_dout = 16'h5678; fir_dout_valid = 1'b1; m_dout_ready = 1'b0;
    sel_set = 2'd2; sel_valid = 1'b1; #1;
    check("res_vld", 32'(m_dout_valid), 1);
    check("res_data", 32'(m_dout), 32'h5678);
    check("res_rdy", 32'(fir_dout_ready), 0);
    check("sel2_rdy", 32'(sel_ready), 1);
    @(negedge clk); sel_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("drain_busy", 32'(busy), 1);
      check("drain_s_rdy", 32'(s_din_ready), 0);
      check("drain_din_vld", 32'(fir_din_valid), 0);
      @(negedge clk);
    end
    m_dout_ready = 1'b1; #1;
    check("drain_res_rdy", 32'(fir_dout_ready), 1);
    @(negedge clk);
    m_dout_ready = 1'b0; fir_dout_valid = 1'b0; s_din_valid = 1'b0; #1;
    check("drain_last_busy", 32'(busy), 1);
    check("drain_last_en", 32'(fir_enable), 1);
    @(negedge clk);
    load_check(2, 1'b0, 1'b1);

    // Pending select of set 3 is taken in RUN; written tap 5 must appear
    @(negedge clk); sel_valid = 1'b0; #1;
    check("drain3_busy", 32'(busy), 1);
    @(negedge clk);
    load_check(3, 1'b0, 1'b0);

    // Reset in the middle of a load
    sel_set = 2'd1; sel_valid = 1'b1; fir_tap_din_ready = 1'b1;
    @(negedge clk); sel_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("mid_load_vld", 32'(fir_tap_din_valid), 1);
    reset = 1'b1;
    @(negedge clk); #1;
    check("mrst_en", 32'(fir_enable), 0);
    check("mrst_tap_vld", 32'(fir_tap_din_valid), 0);
    check("mrst_loaded", 32'(loaded), 0);
    check("mrst_active", 32'(active_set), 0);
    check("mrst_busy", 32'(busy), 0);
    reset = 1'b0; fir_tap_din_ready = 1'b0;
    @(negedge clk);

    sel_set = 2'd2; sel_valid = 1'b1; #1;
    check("post_rst_sel_rdy", 32'(sel_ready), 1);
    @(negedge clk); sel_valid = 1'b0;
    load_check(2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
